mc_ctrl: RTL

- Multi-cycle control unit on the consuming end of the fetch unit's interface.
- Takes the fetched instruction and current PC, and steps each instruction through a FETCH/DECODE/EXEC/MEM/WB state machine.
- Drives datapath enables and returns the PC-update controls (pc_we, pc_src, pc_jump, pc_branch, reg_to_pc) to the fetch unit.
- Exactly one PC update per instruction, issued in the instruction's final state.

---
 rtl/mc_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: steps each fetched instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives datapath enables and hands exactly one PC update per instruction back to the fetch unit.
module mc_ctrl #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs_data,
  input  logic        alu_zero,
  output logic        pc_we,
  output logic        pc_src,
  output logic        pc_jump,
  output logic [31:0] pc_branch,
  output logic [31:0] reg_to_pc,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        ext_op,
  output logic        mem_we,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    K_NOP, K_ADDU, K_SUBU, K_JR, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_J, K_JAL
  } kind_t;

  state_t      st, st_nxt;
  logic [31:0] ir;
  kind_t       kind;
  logic        last;
  logic [31:0] pc_plus4;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    kind = K_NOP;
    case (ir[31:26])
      6'b000000: begin
        case (ir[5:0])
          6'b100001: kind = K_ADDU;
          6'b100011: kind = K_SUBU;
          6'b001000: kind = K_JR;
          default:   kind = K_NOP;
        endcase
      end
      6'b001101: kind = K_ORI;
      6'b100011: kind = K_LW;
      6'b101011: kind = K_SW;
      6'b000100: kind = K_BEQ;
      6'b001111: kind = K_LUI;
      6'b000010: kind = K_J;
      6'b000011: kind = K_JAL;
      default:   kind = K_NOP;
    endcase
  end

  // last marks the instruction's final state, the one that carries its single PC update.
  always_comb begin
    st_nxt = S_FETCH;
    last   = 1'b0;
    case (st)
      S_FETCH:  st_nxt = S_DECODE;
      S_DECODE: begin
        case (kind)
          K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ: st_nxt = S_EXEC;
          K_JAL:   st_nxt = S_WB;
          default: last   = 1'b1;
        endcase
      end
      S_EXEC: begin
        case (kind)
          K_LW, K_SW: st_nxt = S_MEM;
          K_BEQ:      last   = 1'b1;
          default:    st_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (kind == K_LW) st_nxt = S_WB;
        else              last   = 1'b1;
      end
      S_WB:    last   = 1'b1;
      default: st_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      st <= state_t'(RESET_STATE);
      ir <= '0;
    end else begin
      st <= st_nxt;
      if (st == S_FETCH) ir <= instr;
    end
  end

  // Enables are masked by reset so an abandoned instruction never writes anything.
  assign pc_we   = last & ~reset;
  assign pc_src  = pc_we & (kind == K_BEQ) & alu_zero;
  assign pc_jump = pc_we & (kind inside {K_J, K_JAL, K_JR});
  assign reg_we  = (st == S_WB) & ~reset;
  assign mem_we  = (st == S_MEM) & (kind == K_SW) & ~reset;

  assign alu_src = (st == S_EXEC) & (kind inside {K_ORI, K_LUI, K_LW, K_SW});
  assign ext_op  = kind inside {K_LW, K_SW, K_BEQ};

  always_comb begin
    alu_op  = 3'd0;
    reg_dst = 2'd0;
    wd_sel  = 2'd0;
    if (st == S_EXEC) begin
      case (kind)
        K_SUBU, K_BEQ: alu_op = 3'd1;
        K_ORI:         alu_op = 3'd2;
        K_LUI:         alu_op = 3'd3;
        default:       alu_op = 3'd0;
      endcase
    end
    if (st == S_WB) begin
      if (kind inside {K_ADDU, K_SUBU}) reg_dst = 2'd1;
      else if (kind == K_JAL)           reg_dst = 2'd2;
      if (kind == K_LW)       wd_sel = 2'd1;
      else if (kind == K_JAL) wd_sel = 2'd2;
    end
  end

  assign pc_plus4  = pc + 32'd4;
  assign pc_branch = {{14{ir[15]}}, ir[15:0], 2'b00};
  assign reg_to_pc = (kind == K_JR) ? rs_data : {pc_plus4[31:28], ir[25:0], 2'b00};
  assign state     = st;

endmodule
